otg_hpi_responder: RTL

OTG_HPI_RESPONDER -- requirements
Module: otg_hpi_responder

---
 rtl/hpi_pkg.sv | 29 ++
 rtl/hpi_resp_ram.sv | 25 ++
 rtl/otg_hpi_responder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/hpi_pkg.sv
// Shared definitions for the OTG host-port-interface responder.
package hpi_pkg;

    localparam int unsigned HPI_DW = 16;
    localparam int unsigned HPI_AW = 2;

    localparam logic [HPI_AW-1:0] HPI_DATA    = 2'd0;
    localparam logic [HPI_AW-1:0] HPI_MAILBOX = 2'd1;
    localparam logic [HPI_AW-1:0] HPI_ADDRESS = 2'd2;
    localparam logic [HPI_AW-1:0] HPI_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_ACTIVE = 2'd1,
        ST_WR_ACTIVE = 2'd2
    } hpi_state_e;

    localparam int unsigned STAT_FULL_BIT = 0;
    localparam int unsigned STAT_INT_BIT  = 1;

    function automatic logic [HPI_DW-1:0] status_word(input logic irq, input logic full);
        logic [HPI_DW-1:0] w;
        w                = '0;
        w[STAT_INT_BIT]  = irq;
        w[STAT_FULL_BIT] = full;
        return w;
    endfunction

endpackage

// File: rtl/hpi_resp_ram.sv
// Single-port synchronous RAM, one-cycle read latency, contents not reset.
module hpi_resp_ram #(
    parameter int unsigned WORDS = 256,
    parameter int unsigned AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem_q [WORDS];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/otg_hpi_responder.sv
// HPI slave: registered host strobes, byte pointer into local RAM, and a
// mailbox pair between the host and a local agent.
module otg_hpi_responder
    import hpi_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [1:0]  hpi_addr,
    input  logic [15:0] hpi_data_in,
    output logic [15:0] hpi_data_out,
    output logic        hpi_data_oe,
    input  logic        hpi_cs_n,
    input  logic        hpi_rd_n,
    input  logic        hpi_wr_n,
    input  logic        hpi_rst_n,
    output logic        hpi_int,
    output logic [15:0] loc_mbx_rdata,
    output logic        loc_mbx_full,
    input  logic        loc_mbx_ack,
    input  logic [15:0] loc_mbx_wdata,
    input  logic        loc_mbx_wr
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic        s_cs_n_q, s_rd_n_q, s_wr_n_q, s_rst_n_q;
    logic        p_cs_n_q, p_rd_n_q, p_wr_n_q;
    logic [1:0]  s_addr_q;
    logic [15:0] s_data_q;

    hpi_state_e  state_q, state_d;
    logic        rd_wait_q, rd_wait_d;
    logic [1:0]  acc_addr_q, acc_addr_d;
    logic [15:0] acc_data_q, acc_data_d;
    logic [15:0] ptr_q, ptr_d;
    logic [15:0] out_mbx_q, out_mbx_d;
    logic [15:0] in_mbx_q, in_mbx_d;
    logic        full_q, full_d;
    logic        int_q, int_d;
    logic [15:0] dout_q, dout_d;
    logic        oe_q, oe_d;

    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [15:0] rd_src;
    logic        rd_mbx_done;
    logic        host_mbx_wr;
    logic        rd_fall, rd_rise, wr_fall, wr_rise, cs_rise;

    // Host input capture; the previous copy feeds edge detection.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            s_cs_n_q  <= 1'b1;
            s_rd_n_q  <= 1'b1;
            s_wr_n_q  <= 1'b1;
            s_rst_n_q <= 1'b1;
            p_cs_n_q  <= 1'b1;
            p_rd_n_q  <= 1'b1;
            p_wr_n_q  <= 1'b1;
            s_addr_q  <= '0;
            s_data_q  <= '0;
        end else begin
            s_cs_n_q  <= hpi_cs_n;
            s_rd_n_q  <= hpi_rd_n;
            s_wr_n_q  <= hpi_wr_n;
            s_rst_n_q <= hpi_rst_n;
            p_cs_n_q  <= s_cs_n_q;
            p_rd_n_q  <= s_rd_n_q;
            p_wr_n_q  <= s_wr_n_q;
            s_addr_q  <= hpi_addr;
            s_data_q  <= hpi_data_in;
        end
    end

    assign rd_fall = p_rd_n_q & ~s_rd_n_q;
    assign rd_rise = ~p_rd_n_q & s_rd_n_q;
    assign wr_fall = p_wr_n_q & ~s_wr_n_q;
    assign wr_rise = ~p_wr_n_q & s_wr_n_q;
    assign cs_rise = ~p_cs_n_q & s_cs_n_q;

    hpi_resp_ram #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk_clk),
        .we    (ram_we),
        .addr  (ptr_q[AW:1]),
        .wdata (acc_data_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        rd_src = '0;
        case (acc_addr_q)
            HPI_DATA:    rd_src = ram_rdata;
            HPI_MAILBOX: rd_src = out_mbx_q;
            HPI_ADDRESS: rd_src = ptr_q;
            default:     rd_src = status_word(int_q, full_q);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rd_wait_d   = rd_wait_q;
        acc_addr_d  = acc_addr_q;
        acc_data_d  = acc_data_q;
        ptr_d       = ptr_q;
        out_mbx_d   = out_mbx_q;
        in_mbx_d    = in_mbx_q;
        full_d      = full_q;
        int_d       = int_q;
        dout_d      = dout_q;
        oe_d        = 1'b0;
        ram_we      = 1'b0;
        rd_mbx_done = 1'b0;
        host_mbx_wr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rd_wait_d  = 1'b0;
                acc_addr_d = s_addr_q;
                acc_data_d = s_data_q;
                if (!s_cs_n_q && rd_fall && s_wr_n_q) begin
                    state_d = ST_RD_ACTIVE;
                end else if (!s_cs_n_q && wr_fall && s_rd_n_q) begin
                    state_d = ST_WR_ACTIVE;
                end
            end
            ST_RD_ACTIVE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (rd_rise) begin
                    state_d = ST_IDLE;
                    if (acc_addr_q == HPI_DATA) begin
                        ptr_d = ptr_q + 16'd2;
                    end
                    rd_mbx_done = (acc_addr_q == HPI_MAILBOX);
                end else begin
                    // First cycle lets the RAM read settle; drive from the second.
                    rd_wait_d = 1'b1;
                    oe_d      = rd_wait_q;
                    if (rd_wait_q) begin
                        dout_d = rd_src;
                    end
                end
            end
            ST_WR_ACTIVE: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (wr_rise) begin
                    state_d = ST_IDLE;
                    case (acc_addr_q)
                        HPI_DATA: begin
                            ram_we = 1'b1;
                            ptr_d  = ptr_q + 16'd2;
                        end
                        HPI_MAILBOX: host_mbx_wr = 1'b1;
                        HPI_ADDRESS: ptr_d = acc_data_q;
                        default: ;
                    endcase
                end else begin
                    acc_addr_d = s_addr_q;
                    acc_data_d = s_data_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Host commit overrides a same-cycle local ack.
        if (loc_mbx_ack) begin
            full_d = 1'b0;
        end
        if (host_mbx_wr) begin
            in_mbx_d = acc_data_q;
            full_d   = 1'b1;
        end

        // Local load overrides a same-cycle host mailbox read.
        if (rd_mbx_done) begin
            int_d = 1'b0;
        end
        if (loc_mbx_wr) begin
            out_mbx_d = loc_mbx_wdata;
            int_d     = 1'b1;
        end

        if (!s_rst_n_q) begin
            state_d   = ST_IDLE;
            rd_wait_d = 1'b0;
            ptr_d     = '0;
            out_mbx_d = '0;
            in_mbx_d  = '0;
            full_d    = 1'b0;
            int_d     = 1'b0;
            oe_d      = 1'b0;
            ram_we    = 1'b0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q    <= ST_IDLE;
            rd_wait_q  <= 1'b0;
            acc_addr_q <= '0;
            acc_data_q <= '0;
            ptr_q      <= '0;
            out_mbx_q  <= '0;
            in_mbx_q   <= '0;
            full_q     <= 1'b0;
            int_q      <= 1'b0;
            dout_q     <= '0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_wait_q  <= rd_wait_d;
            acc_addr_q <= acc_addr_d;
            acc_data_q <= acc_data_d;
            ptr_q      <= ptr_d;
            out_mbx_q  <= out_mbx_d;
            in_mbx_q   <= in_mbx_d;
            full_q     <= full_d;
            int_q      <= int_d;
            dout_q     <= dout_d;
            oe_q       <= oe_d;
        end
    end

    assign hpi_data_out  = dout_q;
    assign hpi_data_oe   = oe_q;
    assign hpi_int       = int_q;
    assign loc_mbx_rdata = in_mbx_q;
    assign loc_mbx_full  = full_q;

endmodule
